// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// exception vector and PC increment.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;
    localparam logic [31:0] PC_INCR    = 32'd4;

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_sel.sv
// Next-PC selection: priority mux jr > jump > taken branch > sequential,
// all relative to the address of the instruction being retired.
module next_pc_sel
    import pc_fetch_pkg::*;
(
    input  logic [31:0] instr_pc,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] jump_pc;

    assign seq_pc  = instr_pc + PC_INCR;
    assign br_pc   = seq_pc + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign jump_pc = {seq_pc[31:28], jump_index, 2'b00};

    always_comb begin
        if (jr)
            next_pc = jr_target;
        else if (jump)
            next_pc = jump_pc;
        else if (br_taken)
            next_pc = br_pc;
        else
            next_pc = seq_pc;
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, runs the imem req/ack handshake
// with timeout/retry, and hands instructions to decode. Optional macro: PC_MISALIGN_TRAP_EN.
module pc_fetch_sequencer
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 15,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic        fetch_fault
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap,
    output logic [31:0] bad_pc
`endif
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(IMEM_TIMEOUT - 1);
    localparam logic [7:0] RETRY_LAST   = 8'(MAX_RETRY - 1);

    fetch_state_e state, state_nxt;
    logic [7:0]   timeout_cnt;
    logic [7:0]   retry_cnt;
    logic         handshake;
    logic         timed_out;
    logic [31:0]  sel_pc;
    logic [31:0]  load_pc;

    assign handshake = (state == ISSUE) && instr_ready;
    assign timed_out = (state == WAIT) && !imem_ack && (timeout_cnt == TIMEOUT_LAST);
    assign imem_addr = pc;

    next_pc_sel u_next_pc_sel (
        .instr_pc   (instr_pc),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .jump       (jump),
        .jump_index (jump_index),
        .jr         (jr),
        .jr_target  (jr_target),
        .next_pc    (sel_pc)
    );

`ifdef PC_MISALIGN_TRAP_EN
    logic misaligned;

    assign misaligned    = (sel_pc[1:0] != 2'b00);
    assign load_pc       = misaligned ? EXC_VECTOR : sel_pc;
    assign misalign_trap = handshake && misaligned;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            bad_pc <= '0;
        else if (misalign_trap)
            bad_pc <= sel_pc;
    end
`else
    assign load_pc = {sel_pc[31:2], 2'b00};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // Outputs decode straight from state, so an async reset mid-WAIT drops imem_req at once.
    always_comb begin
        // NOTE: every output gets a default before the case, otherwise a latch is inferred.
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_fault = 1'b0;
        case (state)
            FETCH: begin
                if (!stall)
                    state_nxt = WAIT;
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_nxt = ISSUE;
                else if (timed_out)
                    state_nxt = (retry_cnt == RETRY_LAST) ? HALT : FETCH;
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready)
                    state_nxt = FETCH;
            end
            HALT: begin
                fetch_fault = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            timeout_cnt <= '0;
            retry_cnt   <= '0;
        end else begin
            if (state == WAIT) begin
                if (imem_ack) begin
                    instr       <= imem_rdata;
                    instr_pc    <= pc;
                    timeout_cnt <= '0;
                    retry_cnt   <= '0;
                end else if (timed_out) begin
                    timeout_cnt <= '0;
                    retry_cnt   <= retry_cnt + 8'd1;
                end else begin
                    timeout_cnt <= timeout_cnt + 8'd1;
                end
            end
            if (handshake)
                pc <= load_pc;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: expected fetch addresses are queued when a
// redirect is driven and compared when the DUT raises imem_req.
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic        fetch_fault;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic [31:0] bad_pc;
`endif

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          valid_cyc  = 0;
    logic [31:0] addr_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    pc_fetch_sequencer #(
        .RESET_PC     (32'h0000_0000),
        .IMEM_TIMEOUT (4),
        .MAX_RETRY    (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jump        (jump),
        .jump_index  (jump_index),
        .jr          (jr),
        .jr_target   (jr_target),
        .pc          (pc),
        .fetch_fault (fetch_fault)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_trap (misalign_trap),
        .bad_pc        (bad_pc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("req_seen", imem_req, 1);
    endtask

    // One full instruction: request, ack after ack_delay extra WAIT cycles, hold in ISSUE
    // for ready_delay cycles, then retire with the given redirect inputs.
    task automatic do_instr(input string tag, input logic [31:0] word,
                            input int ack_delay, input int ready_delay,
                            input logic d_jr, input logic [31:0] d_jr_target,
                            input logic d_jump, input logic [25:0] d_index,
                            input logic d_br, input logic [15:0] d_offset,
                            input logic [31:0] next_exp, input logic exp_trap);
        logic [31:0] a;
        wait_req();
        a = addr_q.pop_front();
        check({tag, ":addr"}, imem_addr, a);
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clock);
            check({tag, ":req_hold"}, imem_req, 1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clock);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        valid_cyc  = cyc;
        check({tag, ":valid"}, instr_valid, 1);
        check({tag, ":instr"}, instr, word);
        check({tag, ":instr_pc"}, instr_pc, a);
        instr_ready = 1'b0;
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clock);
            check({tag, ":bp_valid"}, instr_valid, 1);
            check({tag, ":bp_instr"}, instr, word);
            check({tag, ":bp_instr_pc"}, instr_pc, a);
            check({tag, ":bp_no_req"}, imem_req, 0);
        end
        instr_ready = 1'b1;
        jr          = d_jr;
        jr_target   = d_jr_target;
        jump        = d_jump;
        jump_index  = d_index;
        br_taken    = d_br;
        br_offset   = d_offset;
        #1;
`ifdef PC_MISALIGN_TRAP_EN
        check({tag, ":trap"}, misalign_trap, exp_trap);
`else
        if (exp_trap) a = '0;
`endif
        addr_q.push_back(next_exp);
        @(negedge clock);
        instr_ready = 1'b0;
        jr = 1'b0; jr_target = '0; jump = 1'b0; jump_index = '0; br_taken = 1'b0; br_offset = '0;
        check({tag, ":pc"}, pc, next_exp);
        check({tag, ":valid_drop"}, instr_valid, 0);
    endtask

    // One unanswered request: held 4 cycles, dropped for one, re-issued to the same address.
    task automatic miss_cycle(input string tag, input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            check({tag, ":req"}, imem_req, 1);
            check({tag, ":addr"}, imem_addr, a);
            @(negedge clock);
        end
        check({tag, ":dropped"}, imem_req, 0);
        @(negedge clock);
        check({tag, ":reissue"}, imem_req, 1);
        check({tag, ":reissue_addr"}, imem_addr, a);
    endtask

    initial begin
        int v0;
        reset = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        br_taken = 1'b0; br_offset = '0; jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0;
        repeat (2) @(negedge clock);
        check("rst:pc", pc, 32'h0);
        check("rst:req", imem_req, 0);
        check("rst:valid", instr_valid, 0);
        check("rst:instr", instr, 32'h0);
        check("rst:instr_pc", instr_pc, 32'h0);
        check("rst:fault", fetch_fault, 0);
`ifdef PC_MISALIGN_TRAP_EN
        check("rst:bad_pc", bad_pc, 32'h0);
`endif
        reset = 1'b0;
        addr_q.push_back(32'h0);

        // Sequential stream at minimum latency
        do_instr("seq0", 32'h2000_0001, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);
        v0 = valid_cyc;
        do_instr("seq1", 32'h2000_0002, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0);
        check("seq:period1", valid_cyc - v0, 3);
        v0 = valid_cyc;
        do_instr("seq2", 32'h2000_0003, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0);
        check("seq:period2", valid_cyc - v0, 3);

        // Stall in FETCH holds off the request
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("stall:no_req", imem_req, 0);
        end
        stall = 1'b0;

        // Backpressure, then branches around 0x10
        do_instr("bp_jr", 32'h0300_0008, 0, 5, 1, 32'h10, 0, 0, 0, 0, 32'h10, 0);
        do_instr("br_back", 32'h1000_FFFC, 0, 0, 0, 0, 0, 0, 1, 16'hFFFC, 32'h4, 0);
        do_instr("jr_10", 32'h0300_0008, 0, 0, 1, 32'h10, 0, 0, 0, 0, 32'h10, 0);
        do_instr("br_fwd", 32'h1000_0003, 0, 0, 0, 0, 0, 0, 1, 16'h0003, 32'h20, 0);

        // Priority jr > jump > branch
        do_instr("jr_hi", 32'h0300_0008, 0, 0, 1, 32'h1000_0000, 0, 0, 0, 0, 32'h1000_0000, 0);
        do_instr("prio", 32'h0800_0040, 0, 0, 1, 32'h400, 1, 26'h40, 1, 16'h0010, 32'h400, 0);
        do_instr("jr_hi2", 32'h0300_0008, 0, 0, 1, 32'h1000_0000, 0, 0, 0, 0, 32'h1000_0000, 0);
        do_instr("jump", 32'h0800_0040, 0, 0, 0, 0, 1, 26'h40, 1, 16'h0010, 32'h1000_0100, 0);

        // Misaligned jr target
`ifdef PC_MISALIGN_TRAP_EN
        do_instr("misal", 32'h0300_0008, 0, 0, 1, 32'h102, 0, 0, 0, 0, 32'h80, 1);
        check("misal:bad_pc", bad_pc, 32'h102);
        check("misal:trap_pulse", misalign_trap, 0);
`else
        do_instr("misal", 32'h0300_0008, 0, 0, 1, 32'h102, 0, 0, 0, 0, 32'h100, 1);
`endif

        // Wrap at the top of the address space
        do_instr("jr_top", 32'h0300_0008, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
        do_instr("wrap", 32'h2000_0004, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);

        // Ack in the timeout cycle is accepted
        do_instr("ack_late", 32'h2000_0005, 3, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);

        // One timeout then ack; retry count must clear
        wait_req();
        miss_cycle("to1", addr_q[0]);
        do_instr("retry_ok", 32'h2000_0006, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0);

        // Three timeouts -> fault and HALT
        wait_req();
        miss_cycle("to_a", addr_q[0]);
        miss_cycle("to_b", addr_q[0]);
        for (int i = 0; i < 4; i++) begin
            check("to_c:req", imem_req, 1);
            @(negedge clock);
        end
        check("halt:fault", fetch_fault, 1);
        imem_ack = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("halt:no_req", imem_req, 0);
            check("halt:no_valid", instr_valid, 0);
            @(negedge clock);
        end
        check("halt:sticky", fetch_fault, 1);
        imem_ack = 1'b0;
        instr_ready = 1'b0;

        // Reset clears the fault
        reset = 1'b1;
        @(negedge clock);
        check("rst2:fault", fetch_fault, 0);
        check("rst2:pc", pc, 32'h0);
        check("rst2:req", imem_req, 0);
        reset = 1'b0;

        // Reset in WAIT drops the request asynchronously
        wait_req();
        check("rst3:addr", imem_addr, 32'h0);
        #2 reset = 1'b1;
        #1 check("rst3:req_drop", imem_req, 0);
        @(negedge clock);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
